sprite_pixel_resolver: RTL and testbench
========================================

Name: sprite_pixel_resolver

Overview:
- Pipelined, multi-sprite successor to the single-sprite combinational hit test.
- Accepts one VGA pixel coordinate per clock and tests it against NUM_SPRITES sprite descriptors, which are latched once per frame.
- Reports, a fixed 3 cycles later, whether any sprite covers the pixel, which one wins (lowest ID) and the sprite-ROM index for that pixel.
- Sits between the VGA timing generator and the sprite ROM / colour mux.

Parameters:
- NUM_SPRITES, 2, number of sprite channels (1..8)
- SPRITE_W, 256, sprite ROM row pitch and nominal box width in pixels
- SPRITE_H, 125, box height in pixels
- SCREEN_H, 480, screen height, used for the Y-axis flip
- COORD_W, 19, coordinate and index width
- DESC_W, 160, bits per sprite descriptor

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; latches sprite_data/sprite_en into shadow registers
- sprite_data  in  NUM_SPRITES*DESC_W  packed descriptors; sprite k at [k*DESC_W +: DESC_W]
- sprite_en  in  NUM_SPRITES  per-sprite enable
- pix_valid  in  1  pixel coordinate valid this cycle
- pix_x  in  COORD_W  pixel X (0 = left)
- pix_y  in  COORD_W  pixel Y (0 = top, pointing down)
- out_valid  out  1  result valid
- out_hit  out  1  at least one enabled sprite covers the pixel
- out_id  out  3  winning sprite ID (lowest-numbered hit); 0 when no hit
- out_index  out  COORD_W  ROM index for the winning sprite; 0 when no hit
- collision  out  1  sticky overlap flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (async, resetn=0):
  - all outputs 0;
  - shadow descriptors 0; shadow enables 0, so there are no hits until the first frame_start;
  - pipeline valids cleared.
- Descriptor fields, per sprite:
  - cx = [63:48], by = [47:32], w = [31:16], facing = [90] (1 = normal, 0 = mirrored).
- Bounds, 16-bit modulo, zero-extended to COORD_W:
  - L = cx - ((SPRITE_W - w) >> 1);
  - R = L + SPRITE_W;
  - B = by;
  - T = B + SPRITE_H.
- Hit test, strict inequalities on all four edges:
  - tY = SCREEN_H - pix_y;
  - hit_k = en_k & (pix_x > L) & (pix_x < R) & (tY > B) & (tY < T).
  - Pixels on any edge are misses.
- Index, truncated to COORD_W:
  - row = pix_y - (SCREEN_H - T);
  - normal = pix_x - L + row*SPRITE_W;
  - mirrored = R - pix_x + row*SPRITE_W.
- Pipeline, no backpressure, one pixel per clock:
  - S1 registers the coordinate and computes bounds from the shadow registers.
  - S2 registers per-sprite hit and index.
  - S3 does the priority select and registers the outputs.
  - out_valid = pix_valid delayed 3 cycles. Outputs are held when out_valid = 0 and change only with out_valid.
- frame_start:
  - The shadow update takes effect for pixels presented in the cycle after the pulse.
  - A pixel presented in the same cycle as frame_start uses the old descriptors.
  - In-flight pixels complete with the descriptors they sampled.
- Simultaneous hits: lowest k wins; the index is that sprite's index.
- resetn asserted mid-stream: the pipeline flushes immediately and no stale out_valid appears after release.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Defined:
  - collision is set, at S3, on any valid pixel where two or more sprites hit.
  - It stays set until the next frame_start, which clears it. Set wins if a set and the clear occur in the same cycle.
  - Reset value 0.
- Undefined: no collision logic; collision is tied to 0.

Decomposition:
- Package sprite_pkg holds:
  - descriptor field offsets (CX_MSB/LSB, BY_MSB/LSB, W_MSB/LSB, FACING_BIT);
  - SCREEN_H;
  - the ID width constant.
- One natural sub-module, sprite_bounds_unit, instantiated NUM_SPRITES times: it takes one shadow descriptor plus the S1 coordinate and returns the registered hit and index.

Test Plan:
- Reset and idle:
  - resetn=0 with pix_valid=1 -> all outputs 0.
  - After release, with no frame_start -> out_hit=0 for all pixels.
- Normal hit:
  - Sprite0: cx=300, by=100, w=256, facing=1, en=1; frame_start.
  - Pixel (301,300) -> 3 cycles later out_valid=1, out_hit=1, out_id=0, out_index=11521.
- Mirrored hit: same setup with facing=0 -> out_index=11775.
- Edge misses, same sprite:
  - pixels (300,300) and (556,300) -> out_hit=0;
  - pixels (301,380) and (301,255) -> out_hit=0.
- Priority and collision:
  - Sprite0 and sprite1 share identical descriptors; pixel (301,300) -> out_id=0.
  - With SPRITE_COLLISION_EN, collision=1 and holds until the next frame_start.
- Frame latch:
  - Change cx to 400 without frame_start -> pixel (301,300) still hits.
  - After frame_start -> the same pixel misses.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite pixel resolver: descriptor field layout,
// screen height used for the Y-axis flip, and the sprite ID width.
package sprite_pkg;

  // Descriptor field positions within one DESC_W-bit sprite record
  localparam int CX_MSB     = 63;
  localparam int CX_LSB     = 48;
  localparam int BY_MSB     = 47;
  localparam int BY_LSB     = 32;
  localparam int W_MSB      = 31;
  localparam int W_LSB      = 16;
  localparam int FACING_BIT = 90;

  // Bounds arithmetic is done modulo 2^16 before widening
  localparam int FIELD_W    = 16;

  // Screen height; Y is flipped so that sprite bottoms are measured upward
  localparam int SCREEN_H   = 480;

  // Width of the winning sprite ID (supports up to 8 sprites)
  localparam int ID_W       = 3;

endpackage

// File: rtl/sprite_bounds_unit.sv
// One sprite channel of the resolver. Registers the sprite's bounding box
// alongside the S1 coordinate (so each pixel keeps the descriptor it
// sampled), then registers the per-sprite hit flag and ROM index at S2.
module sprite_bounds_unit
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 256,
  parameter int SPRITE_H = 125,
  parameter int SCREEN_H = sprite_pkg::SCREEN_H,
  parameter int COORD_W  = 19,
  parameter int DESC_W   = 160
) (
  input  logic               clock_i,
  input  logic [DESC_W-1:0]  desc_i,
  input  logic               en_i,
  input  logic [COORD_W-1:0] x_p1_i,
  input  logic [COORD_W-1:0] y_p1_i,
  output logic               hit_p2_o,
  output logic [COORD_W-1:0] index_p2_o
);

  localparam logic [FIELD_W-1:0] SW16  = FIELD_W'(SPRITE_W);
  localparam logic [FIELD_W-1:0] SH16  = FIELD_W'(SPRITE_H);
  localparam logic [COORD_W-1:0] SW_C  = COORD_W'(SPRITE_W);
  localparam logic [COORD_W-1:0] SCR_C = COORD_W'(SCREEN_H);

  logic [FIELD_W-1:0] cx, by, w;
  logic               facing;
  logic [FIELD_W-1:0] span16, l16, r16, t16;

  // Only a few descriptor bits are meaningful; the rest are reserved
  logic unused_desc;
  assign unused_desc = ^desc_i;

  assign cx     = desc_i[CX_MSB:CX_LSB];
  assign by     = desc_i[BY_MSB:BY_LSB];
  assign w      = desc_i[W_MSB:W_LSB];
  assign facing = desc_i[FACING_BIT];

  // Box edges in 16-bit modular arithmetic (the box is centred on cx)
  always_comb begin
    span16 = SW16 - w;
    l16    = cx - (span16 >> 1);
    r16    = l16 + SW16;
    t16    = by + SH16;
  end

  // ---- S1: bounds registered next to the coordinate
  logic [COORD_W-1:0] l_p1_q, r_p1_q, b_p1_q, t_p1_q;
  logic               facing_p1_q, en_p1_q;

  // Capture the box of the current shadow descriptor every cycle
  always_ff @(posedge clock_i) begin
    l_p1_q      <= COORD_W'(l16);
    r_p1_q      <= COORD_W'(r16);
    b_p1_q      <= COORD_W'(by);
    t_p1_q      <= COORD_W'(t16);
    facing_p1_q <= facing;
    en_p1_q     <= en_i;
  end

  logic [COORD_W-1:0] ty, row, base, index_d;
  logic               hit_d;

  // Strict-inequality hit test and row-major ROM index (mirrored if needed)
  always_comb begin
    ty      = SCR_C - y_p1_i;
    row     = y_p1_i - (SCR_C - t_p1_q);
    base    = row * SW_C;
    hit_d   = en_p1_q & (x_p1_i > l_p1_q) & (x_p1_i < r_p1_q)
                      & (ty > b_p1_q) & (ty < t_p1_q);
    index_d = facing_p1_q ? (x_p1_i - l_p1_q + base)
                          : (r_p1_q - x_p1_i + base);
  end

  // ---- S2: per-sprite hit and index
  logic               hit_p2_q;
  logic [COORD_W-1:0] index_p2_q;

  // Register this channel's result for the priority stage
  always_ff @(posedge clock_i) begin
    hit_p2_q   <= hit_d;
    index_p2_q <= index_d;
  end

  assign hit_p2_o   = hit_p2_q;
  assign index_p2_o = index_p2_q;

endmodule

// File: rtl/sprite_pixel_resolver.sv
// Pipelined multi-sprite hit resolver. One pixel per clock in, result a
// fixed 3 cycles later: any-hit, lowest-ID winner and its sprite-ROM index.
// Descriptors are latched into shadow registers on frame_start.
// Optional sticky overlap detection is built when SPRITE_COLLISION_EN is
// defined; otherwise collision is tied low.
module sprite_pixel_resolver
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_W    = 256,
  parameter int SPRITE_H    = 125,
  parameter int SCREEN_H    = sprite_pkg::SCREEN_H,
  parameter int COORD_W     = 19,
  parameter int DESC_W      = 160
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          frame_start,
  input  logic [NUM_SPRITES*DESC_W-1:0] sprite_data,
  input  logic [NUM_SPRITES-1:0]        sprite_en,
  input  logic                          pix_valid,
  input  logic [COORD_W-1:0]            pix_x,
  input  logic [COORD_W-1:0]            pix_y,
  output logic                          out_valid,
  output logic                          out_hit,
  output logic [ID_W-1:0]               out_id,
  output logic [COORD_W-1:0]            out_index,
  output logic                          collision
);

  localparam int CNT_W = ID_W + 1;

  logic [NUM_SPRITES*DESC_W-1:0] shadow_desc_q;
  logic [NUM_SPRITES-1:0]        shadow_en_q;

  // Shadow descriptors change only on frame_start so a frame sees one set
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shadow_desc_q <= '0;
      shadow_en_q   <= '0;
    end else if (frame_start) begin
      shadow_desc_q <= sprite_data;
      shadow_en_q   <= sprite_en;
    end
  end

  // ---- S1: coordinate capture
  logic               vld_p1_q, vld_p2_q;
  logic [COORD_W-1:0] x_p1_q, y_p1_q;

  // Valid shift register; flushed immediately by reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      vld_p1_q <= pix_valid;
      vld_p2_q <= vld_p1_q;
    end
  end

  // Coordinate register feeding all sprite channels
  always_ff @(posedge clock) begin
    x_p1_q <= pix_x;
    y_p1_q <= pix_y;
  end

  // ---- S2: per-sprite channels
  logic [NUM_SPRITES-1:0] hit_p2;
  logic [COORD_W-1:0]     index_p2 [NUM_SPRITES];

  for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_sprite
    sprite_bounds_unit #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .SCREEN_H (SCREEN_H),
      .COORD_W  (COORD_W),
      .DESC_W   (DESC_W)
    ) u_bounds (
      .clock_i    (clock),
      .desc_i     (shadow_desc_q[k*DESC_W +: DESC_W]),
      .en_i       (shadow_en_q[k]),
      .x_p1_i     (x_p1_q),
      .y_p1_i     (y_p1_q),
      .hit_p2_o   (hit_p2[k]),
      .index_p2_o (index_p2[k])
    );
  end

  logic               hit_d;
  logic [ID_W-1:0]    id_d;
  logic [COORD_W-1:0] index_d;

  // Priority select: scanning downward leaves the lowest hitting ID
  always_comb begin
    hit_d   = 1'b0;
    id_d    = '0;
    index_d = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (hit_p2[k]) begin
        hit_d   = 1'b1;
        id_d    = ID_W'(k);
        index_d = index_p2[k];
      end
    end
  end

  // ---- S3: registered outputs
  logic               out_valid_q, out_hit_q;
  logic [ID_W-1:0]    out_id_q;
  logic [COORD_W-1:0] out_index_q;

  // Result registers; data holds between valid pixels
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_id_q    <= '0;
      out_index_q <= '0;
    end else begin
      out_valid_q <= vld_p2_q;
      if (vld_p2_q) begin
        out_hit_q   <= hit_d;
        out_id_q    <= id_d;
        out_index_q <= index_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_hit   = out_hit_q;
  assign out_id    = out_id_q;
  assign out_index = out_index_q;

`ifdef SPRITE_COLLISION_EN
  logic [CNT_W-1:0] hit_cnt;
  logic             multi_hit;
  logic             collision_q;

  // Count simultaneous hits on the pixel leaving S2
  always_comb begin
    hit_cnt = '0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      hit_cnt = hit_cnt + CNT_W'(hit_p2[k]);
    end
    multi_hit = (hit_cnt >= CNT_W'(2));
  end

  // Sticky overlap flag; a set in the clearing cycle takes priority
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      collision_q <= 1'b0;
    end else if (vld_p2_q && multi_hit) begin
      collision_q <= 1'b1;
    end else if (frame_start) begin
      collision_q <= 1'b0;
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_pixel_resolver.sv
// Self-checking bench for sprite_pixel_resolver: directed vector table,
// hand-written frame/collision sequences, and a randomized stream compared
// every cycle against a behavioural model of the hit/index rules.
module tb_sprite_pixel_resolver;

  localparam int NS   = 2;
  localparam int SW   = 256;
  localparam int SH   = 125;
  localparam int SCR  = 480;
  localparam int CW   = 19;
  localparam int DW   = 160;
  localparam int MASK = (1 << CW) - 1;

  logic              clock = 1'b0;
  logic              resetn;
  logic              frame_start;
  logic [NS*DW-1:0]  sprite_data;
  logic [NS-1:0]     sprite_en;
  logic              pix_valid;
  logic [CW-1:0]     pix_x, pix_y;
  logic              out_valid, out_hit, collision;
  logic [2:0]        out_id;
  logic [CW-1:0]     out_index;

  always #5 clock = ~clock;

  sprite_pixel_resolver #(
    .NUM_SPRITES (NS), .SPRITE_W (SW), .SPRITE_H (SH),
    .SCREEN_H (SCR), .COORD_W (CW), .DESC_W (DW)
  ) dut (
    .clock (clock), .resetn (resetn), .frame_start (frame_start),
    .sprite_data (sprite_data), .sprite_en (sprite_en),
    .pix_valid (pix_valid), .pix_x (pix_x), .pix_y (pix_y),
    .out_valid (out_valid), .out_hit (out_hit), .out_id (out_id),
    .out_index (out_index), .collision (collision)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Pending descriptors (on the inputs) and model shadow copy
  int p_cx[NS], p_by[NS], p_w[NS];
  bit p_f[NS], p_en[NS];
  int m_cx[NS], m_by[NS], m_w[NS];
  bit m_f[NS], m_en[NS];

  // Model pipeline: index 0 newest, index 2 about to be presented
  bit pv[3], ph[3], pm[3];
  int pid[3], pidx[3];
  bit e_valid, e_hit, e_coll;
  int e_id, e_idx;

  function automatic logic [DW-1:0] make_desc(input int cx, input int by,
                                              input int w, input bit f);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    d[63:48] = cx[15:0];
    d[47:32] = by[15:0];
    d[31:16] = w[15:0];
    d[90]    = f;
    return d;
  endfunction

  task automatic set_sprite(input int k, input int cx, input int by,
                            input int w, input bit f, input bit en);
    p_cx[k] = cx; p_by[k] = by; p_w[k] = w; p_f[k] = f; p_en[k] = en;
    sprite_data[k*DW +: DW] = make_desc(cx, by, w, f);
    sprite_en[k] = en;
  endtask

  // Reference: rectangle test on the flipped Y axis, lowest ID wins
  task automatic model_eval(input int x, input int y, output bit hit,
                            output int id, output int idx, output bit multi);
    int n, l, r, b, t, ty, row;
    n = 0; hit = 0; id = 0; idx = 0;
    for (int k = 0; k < NS; k++) begin
      l  = (m_cx[k] - (((SW - m_w[k]) & 'hFFFF) >> 1)) & 'hFFFF;
      r  = (l + SW) & 'hFFFF;
      b  = m_by[k];
      t  = (b + SH) & 'hFFFF;
      ty = (SCR - y) & MASK;
      if (m_en[k] && x > l && x < r && ty > b && ty < t) begin
        n++;
        if (!hit) begin
          hit = 1; id = k;
          row = (y - (SCR - t)) & MASK;
          idx = (m_f[k] ? (x - l + row * SW) : (r - x + row * SW)) & MASK;
        end
      end
    end
    multi = (n >= 2);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_valid"}, out_valid, e_valid);
    chk({tag, "_hit"},   out_hit,   e_hit);
    chk({tag, "_id"},    out_id,    e_id);
    chk({tag, "_index"}, out_index, e_idx);
    chk({tag, "_coll"},  collision, e_coll);
  endtask

  // One clock: model the current inputs, advance, then compare outputs
  task automatic step();
    bit h, mu, fs;
    int id, idx;
    model_eval(int'(pix_x), int'(pix_y), h, id, idx, mu);
    for (int s = 2; s > 0; s--) begin
      pv[s] = pv[s-1]; ph[s] = ph[s-1]; pm[s] = pm[s-1];
      pid[s] = pid[s-1]; pidx[s] = pidx[s-1];
    end
    pv[0] = pix_valid; ph[0] = h; pm[0] = mu; pid[0] = id; pidx[0] = idx;
    fs = frame_start;
    @(posedge clock); #1;
    e_valid = pv[2];
    if (pv[2]) begin e_hit = ph[2]; e_id = pid[2]; e_idx = pidx[2]; end
`ifdef SPRITE_COLLISION_EN
    if (pv[2] && pm[2]) e_coll = 1'b1;
    else if (fs) e_coll = 1'b0;
`endif
    if (fs) begin
      for (int k = 0; k < NS; k++) begin
        m_cx[k] = p_cx[k]; m_by[k] = p_by[k]; m_w[k] = p_w[k];
        m_f[k] = p_f[k]; m_en[k] = p_en[k];
      end
    end
    compare_all("stream");
  endtask

  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      pv[s] = 0; ph[s] = 0; pm[s] = 0; pid[s] = 0; pidx[s] = 0;
    end
    e_valid = 0; e_hit = 0; e_id = 0; e_idx = 0; e_coll = 0;
    for (int k = 0; k < NS; k++) begin
      m_cx[k] = 0; m_by[k] = 0; m_w[k] = 0; m_f[k] = 0; m_en[k] = 0;
    end
    compare_all("reset");
    repeat (cycles) begin
      @(posedge clock); #1;
      compare_all("reset");
    end
    resetn = 1'b1;
  endtask

  task automatic pixel(input bit v, input int x, input int y);
    pix_valid = v; pix_x = CW'(x); pix_y = CW'(y);
  endtask

  task automatic load_frame();
    frame_start = 1'b1; pix_valid = 1'b0;
    step();
    frame_start = 1'b0;
  endtask

  task automatic cfg_apply(input int cfg);
    case (cfg)
      0: begin set_sprite(0, 300, 100, 256, 1, 1); set_sprite(1, 300, 100, 256, 1, 0); end
      1: begin set_sprite(0, 300, 100, 256, 0, 1); set_sprite(1, 300, 100, 256, 1, 0); end
      2: begin set_sprite(0, 300, 100, 256, 1, 1); set_sprite(1, 300, 100, 256, 1, 1); end
      default: begin set_sprite(0, 300, 100, 256, 1, 0); set_sprite(1, 300, 100, 256, 1, 1); end
    endcase
  endtask

  typedef struct {
    int cfg; int x; int y; bit hit; int id; int idx;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{0, 301, 300, 1, 0, 11521};
    vecs[1]  = '{0, 555, 300, 1, 0, 11775};
    vecs[2]  = '{0, 300, 300, 0, 0, 0};
    vecs[3]  = '{0, 556, 300, 0, 0, 0};
    vecs[4]  = '{0, 301, 380, 0, 0, 0};
    vecs[5]  = '{0, 301, 255, 0, 0, 0};
    vecs[6]  = '{0, 301, 256, 1, 0, 257};
    vecs[7]  = '{0, 301, 379, 1, 0, 31745};
    vecs[8]  = '{1, 301, 300, 1, 0, 11775};
    vecs[9]  = '{2, 301, 300, 1, 0, 11521};
    vecs[10] = '{3, 301, 300, 1, 1, 11521};

    resetn = 1'b0; frame_start = 1'b0;
    sprite_data = '0; sprite_en = '0;
    pixel(1, 301, 300);
    cfg_apply(0);
    do_reset(3);

    // Idle after reset: descriptors pending but never latched
    for (int i = 0; i < 6; i++) begin
      pixel(1, 301 + i, 300);
      step();
    end
    chk("idle_no_hit", out_hit, 0);

    // Directed vectors
    foreach (vecs[i]) begin
      cfg_apply(vecs[i].cfg);
      load_frame();
      pixel(1, vecs[i].x, vecs[i].y);
      step();
      pix_valid = 1'b0;
      step();
      step();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_hit", i), out_hit, vecs[i].hit);
      chk($sformatf("vec%0d_id", i), out_id, vecs[i].id);
      chk($sformatf("vec%0d_index", i), out_index, vecs[i].idx);
    end

    // Overlap: sticky until the next frame_start
    cfg_apply(2);
    load_frame();
    pixel(1, 301, 300); step();
    pix_valid = 1'b0;
    repeat (5) step();
`ifdef SPRITE_COLLISION_EN
    chk("coll_held", collision, 1);
`else
    chk("coll_tied", collision, 0);
`endif
    chk("hold_after_valid", out_hit, 1);
    load_frame();
    chk("coll_cleared", collision, 0);

    // Frame latch: descriptor edits apply only after frame_start
    cfg_apply(0);
    load_frame();
    set_sprite(0, 400, 100, 256, 1, 1);
    pixel(1, 301, 300); step();
    pix_valid = 1'b0; step(); step();
    chk("latch_old_hit", out_hit, 1);
    frame_start = 1'b1; pixel(1, 301, 300); step();
    frame_start = 1'b0; pixel(1, 301, 300); step();
    pix_valid = 1'b0; step();
    chk("same_cycle_old_hit", out_hit, 1);
    step();
    chk("after_latch_miss", out_hit, 0);
    chk("after_latch_valid", out_valid, 1);

    // Randomized stream with a mid-stream reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        pixel(1, 301, 300);
        do_reset(2);
      end
      frame_start = ($urandom_range(0, 49) == 0);
      if (frame_start || $urandom_range(0, 29) == 0) begin
        for (int k = 0; k < NS; k++)
          set_sprite(k, $urandom_range(150, 450), $urandom_range(50, 330),
                     $urandom_range(200, 300), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0));
      end
      pixel(($urandom_range(0, 3) != 0), $urandom_range(100, 720),
            $urandom_range(0, 479));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
